ctrl_seq: RTL and testbench

Multi-cycle control sequencer that drives the datapath control end of the ALU/register-file block (RegWrite, ALUsrc, ALUctrl, immOp, rs1, rs2, rd) and consumes its EQ flag. It owns the PC, fetches 32-bit instructions over a request/valid handshake, and decodes an RV32I subset: ADDI, ADD, BEQ, BNE. It steps the datapath through one instruction at a time. Illegal encodings halt the core until reset.

---
 rtl/ctrl_pkg.sv | 45 ++++
 rtl/ctrl_seq_imm_gen.sv | 23 ++
 rtl/ctrl_seq.sv | 143 ++++++++++++++
 tb/tb_ctrl_seq.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types, encodings and decode helper for the control sequencer
package ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        HALT   = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        K_ILLEGAL = 3'd0,
        K_ADDI    = 3'd1,
        K_ADD     = 3'd2,
        K_BEQ     = 3'd3,
        K_BNE     = 3'd4
    } kind_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_ADD = 7'b0000000;

    // Anything outside the supported subset classifies as K_ILLEGAL.
    function automatic kind_e decode_kind(input logic [31:0] ir);
        kind_e k;
        k = K_ILLEGAL;
        if (ir[6:0] == OP_IMM && ir[14:12] == F3_ADD) begin
            k = K_ADDI;
        end else if (ir[6:0] == OP && ir[14:12] == F3_ADD && ir[31:25] == F7_ADD) begin
            k = K_ADD;
        end else if (ir[6:0] == OP_BRANCH && ir[14:12] == F3_BEQ) begin
            k = K_BEQ;
        end else if (ir[6:0] == OP_BRANCH && ir[14:12] == F3_BNE) begin
            k = K_BNE;
        end
        return k;
    endfunction

endpackage

// File: rtl/ctrl_seq_imm_gen.sv
// rtl/ctrl_seq_imm_gen.sv - I-type / B-type sign-extended immediate extraction
module imm_gen #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] ir,
    input  logic                  sel_b,
    output logic [DATA_WIDTH-1:0] imm
);

    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_b;
    logic [12:0]           b_field;

    // B-type scatters the offset; bit 0 is implicitly zero.
    assign b_field = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

    always_comb begin
        imm_i = DATA_WIDTH'($signed(ir[31:20]));
        imm_b = DATA_WIDTH'($signed(b_field));
        imm   = sel_b ? imm_b : imm_i;
    end

endmodule

// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - multi-cycle fetch/decode/exec sequencer for an ADDI/ADD/BEQ/BNE subset
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDRESS_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     instr_req,
    output logic [DATA_WIDTH-1:0]    instr_addr,
    input  logic                     instr_valid,
    input  logic [DATA_WIDTH-1:0]    instr,
    input  logic                     EQ,
    output logic                     RegWrite,
    output logic                     ALUsrc,
    output logic                     ALUctrl,
    output logic [DATA_WIDTH-1:0]    immOp,
    output logic [ADDRESS_WIDTH-1:0] rs1,
    output logic [ADDRESS_WIDTH-1:0] rs2,
    output logic [ADDRESS_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0]    pc,
    output logic                     retire,
    output logic                     halt
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  halt_q, halt_d;

    kind_e                 kind;
    logic                  is_branch;
    logic                  has_imm;
    logic                  taken;
    logic                  fields_on;
    logic [DATA_WIDTH-1:0] imm_raw;

    assign kind      = decode_kind(ir_q[31:0]);
    assign is_branch = (kind == K_BEQ) || (kind == K_BNE);
    assign has_imm   = (kind == K_ADDI) || is_branch;
    assign fields_on = (state_q == DECODE) || (state_q == EXEC);

    imm_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_imm_gen (
        .ir    (ir_q),
        .sel_b (is_branch),
        .imm   (imm_raw)
    );

    // EQ reaches only the next-PC mux, never an output.
    assign taken = ((kind == K_BEQ) && EQ) || ((kind == K_BNE) && !EQ);

    assign instr_addr = pc_q;
    assign pc         = pc_q;
    assign halt       = halt_q;

    always_comb begin
        rs1   = '0;
        rs2   = '0;
        rd    = '0;
        immOp = '0;
        if (fields_on) begin
            rs1 = ADDRESS_WIDTH'(ir_q[19:15]);
            rs2 = ADDRESS_WIDTH'(ir_q[24:20]);
            rd  = ADDRESS_WIDTH'(ir_q[11:7]);
            if (has_imm) begin
                immOp = imm_raw;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        halt_d    = halt_q;
        instr_req = 1'b0;
        RegWrite  = 1'b0;
        ALUsrc    = 1'b0;
        ALUctrl   = 1'b0;
        retire    = 1'b0;

        case (state_q)
            FETCH: begin
                instr_req = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (kind == K_ILLEGAL) begin
                    state_d = HALT;
                    halt_d  = 1'b1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                retire = 1'b1;
                case (kind)
                    K_ADDI: begin
                        ALUsrc   = 1'b1;
                        RegWrite = (ir_q[11:7] != 5'd0);
                    end
                    K_ADD: begin
                        RegWrite = (ir_q[11:7] != 5'd0);
                    end
                    K_BEQ, K_BNE: begin
                        ALUctrl = 1'b1;
                    end
                    default: ;
                endcase
                pc_d    = taken ? (pc_q + imm_raw) : (pc_q + DATA_WIDTH'(4));
                state_d = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            ir_q    <= '0;
            pc_q    <= RESET_PC;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            halt_q  <= halt_d;
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - randomized self-checking bench for ctrl_seq against a per-instruction behavioural model
module tb_ctrl_seq;

    logic        clk;
    logic        rst;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic        EQ;
    logic        RegWrite;
    logic        ALUsrc;
    logic        ALUctrl;
    logic [31:0] immOp;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        retire;
    logic        halt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_pc;

    typedef struct {
        logic [116:0] v;
        string        name;
    } exp_t;

    exp_t exp_q[$];

    ctrl_seq dut (
        .clk         (clk),
        .rst         (rst),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr       (instr),
        .EQ          (EQ),
        .RegWrite    (RegWrite),
        .ALUsrc      (ALUsrc),
        .ALUctrl     (ALUctrl),
        .immOp       (immOp),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .pc          (pc),
        .retire      (retire),
        .halt        (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [116:0] pack(
        input logic req, input logic [31:0] addr, input logic rw, input logic src,
        input logic ctl, input logic [31:0] imm, input logic [4:0] a1, input logic [4:0] a2,
        input logic [4:0] ad, input logic [31:0] p, input logic ret, input logic hlt);
        return {req, addr, rw, src, ctl, imm, a1, a2, ad, p, ret, hlt};
    endfunction

    // 0 illegal, 1 ADDI, 2 ADD, 3 BEQ, 4 BNE
    function automatic int m_kind(input logic [31:0] w);
        int opc, f3, f7;
        opc = int'(w[6:0]);
        f3  = int'(w[14:12]);
        f7  = int'(w[31:25]);
        if (opc == 'h13 && f3 == 0) return 1;
        if (opc == 'h33 && f3 == 0 && f7 == 0) return 2;
        if (opc == 'h63 && f3 == 0) return 3;
        if (opc == 'h63 && f3 == 1) return 4;
        return 0;
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] w);
        int k, v;
        k = m_kind(w);
        v = 0;
        if (k == 1) begin
            v = int'(w[31:20]);
            if (v >= 2048) v = v - 4096;
        end else if (k == 3 || k == 4) begin
            v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            if (v >= 4096) v = v - 8192;
        end
        return 32'(v);
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] d, input logic [4:0] s1, input int imm);
        logic [11:0] u;
        u = 12'(imm);
        return {u, s1, 3'b000, d, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        return {7'b0000000, s2, s1, 3'b000, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] s1,
                                          input logic [4:0] s2, input int imm);
        logic [12:0] u;
        u = 13'(imm);
        return {u[12], u[10:5], s2, s1, f3, u[4:1], u[11], 7'b1100011};
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [116:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = pack(instr_req, instr_addr, RegWrite, ALUsrc, ALUctrl, immOp,
                       rs1, rs2, rd, pc, retire, halt);
            checks++;
            if (act !== e.v) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", e.name, act, e.v);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [116:0] v, input string n);
        exp_t e;
        e.v    = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic push_fetch(input string n);
        push(pack(1'b1, m_pc, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, m_pc, 1'b0, 1'b0), n);
    endtask

    task automatic idle_fetch();
        cyc();
        instr_valid = 1'b0;
        instr       = $urandom;
        push_fetch("fetch_idle");
    endtask

    task automatic do_reset();
        cyc();
        rst         = 1'b1;
        instr_valid = 1'($urandom);
        instr       = $urandom;
        cyc();
        rst         = 1'b0;
        instr_valid = 1'b0;
        m_pc        = 32'h0;
        push_fetch("reset_state");
    endtask

    // One whole instruction: fetch (with waits), decode, then exec or halt.
    task automatic run_instr(input logic [31:0] w, input int waits, input logic eq,
                             input bit rst_exec, input string n);
        int          k;
        logic [31:0] imm;
        logic        rw, taken;
        k   = m_kind(w);
        imm = m_imm(w);
        for (int i = 0; i < waits; i++) begin
            cyc();
            instr_valid = 1'b0;
            instr       = $urandom;
            EQ          = 1'($urandom);
            push_fetch({n, "_wait"});
        end
        cyc();
        instr_valid = 1'b1;
        instr       = w;
        push_fetch({n, "_fetch"});

        cyc();
        instr_valid = 1'($urandom);
        instr       = $urandom;
        EQ          = 1'($urandom);
        push(pack(1'b0, m_pc, 1'b0, 1'b0, 1'b0, imm, w[19:15], w[24:20], w[11:7],
                  m_pc, 1'b0, 1'b0), {n, "_decode"});

        if (k == 0) begin
            for (int i = 0; i < 3; i++) begin
                cyc();
                instr_valid = 1'b1;
                instr       = $urandom;
                push(pack(1'b0, m_pc, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0,
                          m_pc, 1'b0, 1'b1), {n, "_halt"});
            end
            return;
        end

        cyc();
        instr_valid = 1'($urandom);
        instr       = $urandom;
        EQ          = eq;
        if (rst_exec) rst = 1'b1;
        rw = ((k == 1) || (k == 2)) && (w[11:7] != 5'd0);
        push(pack(1'b0, m_pc, rw, k == 1, k >= 3, imm, w[19:15], w[24:20], w[11:7],
                  m_pc, 1'b1, 1'b0), {n, "_exec"});
        taken = ((k == 3) && eq) || ((k == 4) && !eq);
        if (rst_exec) begin
            cyc();
            rst         = 1'b0;
            instr_valid = 1'b0;
            m_pc        = 32'h0;
            push_fetch({n, "_after_rst"});
        end else begin
            m_pc = taken ? (m_pc + imm) : (m_pc + 32'd4);
        end
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'h0;
        EQ          = 1'b0;
        m_pc        = 32'h0;

        check("pin_enc_addi", enc_i(5'd1, 5'd0, 5), 32'h00500093);
        check("pin_enc_bne", enc_b(3'b001, 5'd1, 5'd2, -8), 32'hFE209CE3);
        check("pin_imm_addi", m_imm(32'h00500093), 32'h5);
        check("pin_imm_bne", m_imm(32'hFE209CE3), 32'hFFFFFFF8);
        check("pin_kind_illegal", 32'(m_kind(32'hFFFFFFFF)), 32'h0);

        do_reset();
        run_instr(32'h00500093, 0, 1'b0, 1'b0, "addi_x1_5");
        idle_fetch();
        check("addi_next_addr", instr_addr, 32'h4);

        do_reset();
        for (int i = 0; i < 4; i++) run_instr(enc_i(5'd2, 5'd2, 1), 0, 1'b0, 1'b0, "addi_step");
        check("pin_pc_before_bne", m_pc, 32'h10);
        run_instr(32'hFE209CE3, 0, 1'b0, 1'b0, "bne_eq0");
        check("pin_bne_taken", m_pc, 32'h8);
        idle_fetch();
        check("bne_taken_pc", pc, 32'h8);
        run_instr(enc_i(5'd2, 5'd2, 1), 0, 1'b0, 1'b0, "addi_step");
        run_instr(enc_i(5'd2, 5'd2, 1), 0, 1'b0, 1'b0, "addi_step");
        run_instr(32'hFE209CE3, 0, 1'b1, 1'b0, "bne_eq1");
        idle_fetch();
        check("bne_not_taken_pc", pc, 32'h14);

        run_instr(32'h00100013, 0, 1'b0, 1'b0, "addi_x0");
        run_instr(enc_r(5'd5, 5'd6, 5'd7), 3, 1'b0, 1'b0, "add_wait3");

        run_instr(32'hFFFFFFFF, 1, 1'b0, 1'b0, "illegal");
        check("halt_sticky", 32'(halt), 32'h1);
        do_reset();
        check("halt_cleared", 32'(halt), 32'h0);

        run_instr(32'h00500093, 0, 1'b0, 1'b0, "addi_pre_add");
        run_instr(32'h002081B3, 1, 1'b0, 1'b1, "add_rst_exec");
        check("rst_exec_pc", pc, 32'h0);

        do_reset();
        run_instr(enc_b(3'b000, 5'd3, 5'd4, -4), 0, 1'b1, 1'b0, "beq_wrap");
        idle_fetch();
        check("beq_wrap_pc", pc, 32'hFFFFFFFC);

        for (int n = 0; n < 150; n++) begin
            int          r, waits;
            logic [31:0] w;
            logic [4:0]  a, b, c;
            r     = int'($urandom_range(0, 19));
            waits = int'($urandom_range(0, 3));
            a     = 5'($urandom);
            b     = 5'($urandom);
            c     = 5'($urandom);
            if (r == 0) begin
                w = $urandom | 32'h7F;
                run_instr(w, waits, 1'b0, 1'b0, "rnd_illegal");
                do_reset();
            end else begin
                if (r <= 5) w = enc_i(c, a, int'($urandom_range(0, 4095)) - 2048);
                else if (r <= 10) w = enc_r(c, a, b);
                else if (r <= 15) w = enc_b(3'b000, a, b, int'($urandom_range(0, 4095)) * 2 - 4096);
                else w = enc_b(3'b001, a, b, int'($urandom_range(0, 4095)) * 2 - 4096);
                run_instr(w, waits, 1'($urandom), ($urandom_range(0, 15) == 0), "rnd");
            end
        end

        idle_fetch();
        @(negedge clk);
        @(negedge clk);
        check("exp_queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
